seq_detect_moore: RTL and testbench

SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

---
 rtl/seq_detect_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/seq_detect_moore.sv | 99 +++++++++
 tb/tb_seq_detect_moore.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the Moore serial pattern detector.
// Holds the FSM state encoding used by the detector core.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_HIT  = 2'b10
    } state_t;

    // Width needed to hold a fill level of 0..pat_w.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky
// saturation flag; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Count increments until all-ones; the flag latches on arrival.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
            if (count == (MAX - ONE)) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_moore.sv
// Moore FSM that detects a loadable serial bit pattern, with
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_moore
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             clr_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] F_ONE = FILL_W'(1);

    state_t             state, state_n;
    logic [PAT_W-1:0]   pat, pat_n;
    logic               ovl, ovl_n;
    logic [PAT_W-1:0]   hist, hist_n;
    logic [FILL_W-1:0]  fill, fill_n;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    // State, pattern, mode and history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pat   <= '0;
            ovl   <= 1'b0;
            hist  <= '0;
            fill  <= '0;
        end else begin
            state <= state_n;
            pat   <= pat_n;
            ovl   <= ovl_n;
            hist  <= hist_n;
            fill  <= fill_n;
        end
    end

    // Next-state logic: load, shift accepted bits, flag a match.
    always_comb begin
        state_n  = state;
        pat_n    = pat;
        ovl_n    = ovl;
        hist_n   = hist;
        fill_n   = fill;
        hit      = 1'b0;
        fill_inc = (fill == FULL) ? fill : fill + F_ONE;
        if (pat_load) begin
            pat_n   = pat_in;
            ovl_n   = overlap;
            hist_n  = '0;
            fill_n  = '0;
            state_n = S_SCAN;
        end else begin
            case (state)
                S_IDLE: state_n = S_IDLE;
                S_SCAN, S_HIT: begin
                    state_n = S_SCAN;
                    if (din_valid) begin
                        hist_n = PAT_W'({hist, din});
                        fill_n = fill_inc;
                        if ((hist_n == pat) && (fill_inc == FULL)) begin
                            hit     = 1'b1;
                            state_n = S_HIT;
                            fill_n  = ovl ? fill_inc : '0;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign match = (state == S_HIT);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_count),
        .inc   (hit),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed bench for seq_detect_moore: two instances (CNT_W 8 and 2)
// share stimulus; expected match bits flow through a scoreboard queue.
module tb_seq_detect_moore;
    import seq_detect_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       overlap = 1'b0;
    logic       clr_count = 1'b0;

    logic       match_a, match_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       sat_a, sat_b;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    seq_detect_moore #(.PAT_W(4), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
        .clr_count(clr_count), .match(match_a),
        .match_count(cnt_a), .count_sat(sat_a)
    );

    seq_detect_moore #(.PAT_W(4), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
        .clr_count(clr_count), .match(match_b),
        .match_count(cnt_b), .count_sat(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    // One clock: drive inputs, queue expected match, compare after edge.
    task automatic cyc(input string tag, input bit rst, input bit ld,
                       input bit clr, input bit v, input bit d,
                       input bit em);
        bit e;
        reset     = rst;
        pat_load  = ld;
        clr_count = clr;
        din_valid = v;
        din       = d;
        exp_q.push_back(em);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, 32'(match_a), 32'(e));
        reset     = 1'b0;
        pat_load  = 1'b0;
        clr_count = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic bits(input string tag, input bit [15:0] b,
                        input bit [15:0] em, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(tag, 0, 0, 0, 1, b[i], em[i]);
        end
    endtask

    initial begin
        cyc("reset0", 1, 0, 0, 0, 0, 0);
        cyc("reset1", 1, 0, 0, 0, 0, 0);
        chk("rst_cnt", 32'(cnt_a), 0);
        chk("rst_sat", 32'(sat_a), 0);
        chk("rst_state", 32'(u_a.state), 32'(S_IDLE));

        bits("idle_bits", 16'b1011, 16'b0000, 4);
        chk("idle_cnt", 32'(cnt_a), 0);
        chk("idle_state", 32'(u_a.state), 32'(S_IDLE));

        pat_in = 4'b1011; overlap = 1'b1;
        cyc("load_ovl", 0, 1, 0, 1, 1, 0);
        bits("ovl", 16'b1011011, 16'b0001001, 7);
        chk("ovl_cnt", 32'(cnt_a), 2);

        overlap = 1'b0;
        cyc("load_novl", 0, 1, 1, 1, 1, 0);
        bits("novl", 16'b1011011, 16'b0001000, 7);
        chk("novl_cnt", 32'(cnt_a), 1);

        pat_in = 4'b1111; overlap = 1'b1;
        cyc("load_ones", 0, 1, 1, 0, 0, 0);
        bits("ones", 16'b111111, 16'b000111, 6);
        chk("ones_cnt", 32'(cnt_a), 3);

        pat_in = 4'b1011;
        cyc("load_gap", 0, 1, 1, 0, 0, 0);
        bits("gap_a", 16'b10, 16'b00, 2);
        for (int i = 0; i < 3; i++) cyc("gap_idle", 0, 0, 0, 0, 1, 0);
        bits("gap_b", 16'b11, 16'b01, 2);
        cyc("hit_gap", 0, 0, 0, 0, 0, 0);
        chk("gap_cnt", 32'(cnt_a), 1);
        chk("gap_state", 32'(u_a.state), 32'(S_SCAN));

        cyc("load_rst", 0, 1, 0, 0, 0, 0);
        bits("pre_rst", 16'b101, 16'b000, 3);
        cyc("mid_rst", 1, 0, 0, 1, 1, 0);
        chk("mrst_state", 32'(u_a.state), 32'(S_IDLE));
        chk("mrst_cnt", 32'(cnt_a), 0);
        bits("post_rst", 16'b11011, 16'b00000, 5);
        chk("post_state", 32'(u_a.state), 32'(S_IDLE));

        pat_in = 4'b1111; overlap = 1'b1;
        cyc("load_sat", 0, 1, 0, 0, 0, 0);
        bits("sat", 16'b1111111, 16'b0001111, 7);
        chk("sat_cnt_b", 32'(cnt_b), 3);
        chk("sat_flag_b", 32'(sat_b), 1);
        chk("sat_cnt_a", 32'(cnt_a), 4);
        chk("sat_flag_a", 32'(sat_a), 0);
        chk("sat_match_b", 32'(match_b), 1);
        cyc("clr_hit", 0, 0, 1, 1, 1, 1);
        chk("clr_cnt_b", 32'(cnt_b), 0);
        chk("clr_sat_b", 32'(sat_b), 0);
        chk("clr_cnt_a", 32'(cnt_a), 0);
        cyc("after_clr", 0, 0, 0, 1, 1, 1);
        chk("recnt_b", 32'(cnt_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
